// File: rtl/tx_pkg.sv
// tx_pkg: shared state encoding, line levels and counter sizing for the serial transmit framer.
package tx_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/baud_tick.sv
// baud_tick: per-bit cycle counter; bit_end marks the last clock of each serial bit.
module baud_tick
   import tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic bit_end
);
   localparam int CW = cnt_w(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   logic [CW-1:0] r_cnt;
   assign bit_end = (r_cnt == LAST);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else r_cnt <= (clear || bit_end) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/tx_frame_fsm.sv
// tx_frame_fsm: serialises a word as start, LSB-first data, optional even parity and stop bits,
// driving the select and both inputs of the downstream line mux from registers.
module tx_frame_fsm
   import tx_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              tx_sel,
   output logic              shift_bit,
   output logic              frame_bit,
   output logic              busy,
   output logic              done
);
   localparam int BW = cnt_w(DATA_W);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_sreg, w_sreg_nx;
   logic [BW-1:0]     r_bit_cnt;
   logic              r_parity, r_tx_sel, r_shift_bit, r_frame_bit;
   logic              w_bit_end, w_accept, w_tx_sel_nx, w_shift_nx, w_frame_nx;
   baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (r_state == IDLE),
      .bit_end(w_bit_end)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_accept ? START : IDLE;
         START:   w_next = w_bit_end ? DATA : START;
         DATA:    w_next = (w_bit_end && r_bit_cnt == LAST_DATA) ? ((PARITY_EN != 0) ? PARITY : STOP) : DATA;
         PARITY:  w_next = w_bit_end ? STOP : PARITY;
         STOP:    w_next = (w_bit_end && r_bit_cnt == LAST_STOP) ? IDLE : STOP;
         default: w_next = IDLE;
      endcase
   end
   // line outputs are precomputed from the next state so all three mux inputs switch on one edge
   always_comb begin
      data_ready  = (r_state == IDLE);
      busy        = (r_state != IDLE);
      w_accept    = data_valid && data_ready;
      done        = (r_state == STOP) && (w_next == IDLE);
      w_sreg_nx   = w_accept ? data_in : (r_state == DATA && w_bit_end) ? DATA_W'({1'b1, r_sreg} >> 1) : r_sreg;
      w_tx_sel_nx = (w_next == DATA);
      w_shift_nx  = (w_next == DATA) ? w_sreg_nx[0] : LINE_IDLE;
      w_frame_nx  = (w_next == START) ? START_LVL : (w_next == PARITY) ? r_parity : LINE_IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_sreg      <= '0;
         r_parity    <= 1'b0;
         r_bit_cnt   <= '0;
         r_tx_sel    <= 1'b0;
         r_shift_bit <= LINE_IDLE;
         r_frame_bit <= LINE_IDLE;
      end else begin
         r_sreg      <= w_sreg_nx;
         r_parity    <= w_accept ? ^data_in : r_parity;
         r_bit_cnt   <= (w_next != r_state) ? '0 : (w_bit_end && r_state != IDLE) ? r_bit_cnt + 1'b1 : r_bit_cnt;
         r_tx_sel    <= w_tx_sel_nx;
         r_shift_bit <= w_shift_nx;
         r_frame_bit <= w_frame_nx;
      end
   assign tx_sel    = r_tx_sel;
   assign shift_bit = r_shift_bit;
   assign frame_bit = r_frame_bit;
endmodule
